// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 codes, exception codes, FSM states and size helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_e;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        logic [2:0] s;
        s = 3'd4;
        if (f3[1:0] == 2'b00) s = 3'd1;
        else if (f3[1:0] == 2'b01) s = 3'd2;
        return s;
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        m = 4'b1111;
        if (f3[1:0] == 2'b00) m = 4'b0001;
        else if (f3[1:0] == 2'b01) m = 4'b0011;
        return m;
    endfunction

    function automatic logic is_crossing(input logic [2:0] f3,
                                         input logic [1:0] off);
        logic [2:0] s;
        s = size_of(f3);
        return ((s == 3'd4) && (off != 2'd0)) ||
               ((s == 3'd2) && (off == 2'd3));
    endfunction

    function automatic logic is_legal(input logic       wr,
                                      input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!wr) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed bytes out of
// a two-word window and sign- or zero-extends them.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] raw;

    // Shift the window down to the start byte, then extend by size
    always_comb begin
        raw  = 32'({hi, lo} >> {off, 3'b000});
        data = '0;
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_W:    data = raw;
            F3_BU:   data = {24'h0, raw[7:0]};
            F3_HU:   data = {16'h0, raw[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed requests into word
// memory commands, splitting word-crossing accesses in two.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_exc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic              write_q, write_d;
    logic [1:0]        exc_q, exc_d;

    logic [1:0]        off;
    logic              split;
    logic [ADDR_W-3:0] word_lo, word_hi;
    logic [7:0]        be8;
    logic [63:0]       wide;
    logic [31:0]       ld_hi, ld_lo, ld_data;

    assign off     = addr_q[1:0];
    assign split   = is_crossing(funct3_q, off);
    assign word_lo = addr_q[ADDR_W-1:2];
    assign word_hi = word_lo + {{(ADDR_W-3){1'b0}}, 1'b1};
    assign be8     = {4'b0000, size_mask(funct3_q)} << off;
    assign wide    = {32'h0, wdata_q} << {off, 3'b000};

    // The first-half word sits in lo_q once the second half returns
    assign ld_hi = split ? mem_rdata : 32'h0;
    assign ld_lo = split ? lo_q : mem_rdata;

    lsu_load_align u_align (
        .hi     (ld_hi),
        .lo     (ld_lo),
        .off    (off),
        .funct3 (funct3_q),
        .data   (ld_data)
    );

    // State and request latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            write_q  <= 1'b0;
            exc_q    <= EXC_NONE;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            write_q  <= write_d;
            exc_q    <= exc_d;
        end
    end

    // Next state: accept and classify in IDLE, then walk the halves
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        write_d  = write_q;
        exc_d    = exc_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    write_d  = req_write;
                    exc_d    = EXC_NONE;
                    state_d  = S_LO;
                    if (!is_legal(req_write, req_funct3)) begin
                        exc_d   = EXC_ILLEGAL;
                        state_d = S_DONE;
                    end else if (!SPLIT_MISALIGNED &&
                                 is_crossing(req_funct3, req_addr[1:0])) begin
                        exc_d   = EXC_MISALIGN;
                        state_d = S_DONE;
                    end
                end
            end
            S_LO: state_d = split ? S_HI : S_DONE;
            S_HI: begin
                lo_d    = mem_rdata;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory command and response outputs from state and latched request
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_exc   = EXC_NONE;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_LO: begin
                mem_addr  = {word_lo, 2'b00};
                mem_be    = be8[3:0];
                mem_wdata = wide[31:0];
                mem_read  = !write_q;
                mem_write = write_q;
            end
            S_HI: begin
                mem_addr  = {word_hi, 2'b00};
                mem_be    = be8[7:4];
                mem_wdata = wide[63:32];
                mem_read  = !write_q;
                mem_write = write_q;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_exc   = exc_q;
                if (!write_q && exc_q == EXC_NONE) resp_rdata = ld_data;
            end
            default: ;
        endcase
    end

endmodule
